// File: rtl/axis_fifo_s_frame_sink.sv
// axis_fifo_s_frame_sink: AXI-Stream frame sink that checks frame length and writes beats into a FIFO through a one-deep slice
module axis_fifo_s_frame_sink #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int LENGTH_OF_FRAME      = 1024,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                              s_axis_aclk,
    input  logic                              s_axis_aresetn,
    input  logic                              s_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   fifo_din,
    output logic                              fifo_wr_en,
    input  logic                              fifo_full,
    output logic                              frame_done,
    output logic                              frame_err,
    output logic                              err_short,
    output logic                              err_long,
    output logic [CNT_WIDTH-1:0]              frame_cnt,
    output logic [CNT_WIDTH-1:0]              err_cnt
);
    localparam int BW = $clog2(LENGTH_OF_FRAME);
    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
    state_t                          state_q, state_d;
    logic [BW-1:0]                   beat_cnt_q, beat_cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                            done_q, done_d, err_q, err_d;
    logic                            err_short_q, err_short_d, err_long_q, err_long_d;
    logic [CNT_WIDTH-1:0]            frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic                            accept, at_last, wr, good_hit, short_hit, long_hit;
    logic                            unused_ok;
    assign unused_ok = ^s_axis_tkeep;
    assign s_axis_tready = s_axis_aresetn & ((state_q == DISCARD) | ~out_valid_q | ~fifo_full);
    assign accept  = s_axis_tvalid & s_axis_tready;
    assign at_last = beat_cnt_q == BW'(LENGTH_OF_FRAME - 1);
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end
    // beat_cnt holds the index of the next beat within the current frame
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    state_d    = s_axis_tlast ? IDLE : RECV;
                    beat_cnt_d = s_axis_tlast ? '0 : BW'(1);
                end
                RECV: begin
                    state_d    = s_axis_tlast ? IDLE : (at_last ? DISCARD : RECV);
                    beat_cnt_d = (s_axis_tlast | at_last) ? '0 : beat_cnt_q + BW'(1);
                end
                default: begin
                    state_d    = s_axis_tlast ? IDLE : DISCARD;
                    beat_cnt_d = '0;
                end
            endcase
        end
    end
    always_comb begin
        wr          = accept & (state_q != DISCARD);
        good_hit    = accept & s_axis_tlast & (state_q == RECV) & at_last;
        short_hit   = accept & s_axis_tlast & ((state_q == IDLE) | ((state_q == RECV) & ~at_last));
        long_hit    = accept & ~s_axis_tlast & (state_q == RECV) & at_last;
        out_valid_d = wr | (out_valid_q & fifo_full);
        out_data_d  = wr ? s_axis_tdata : out_data_q;
        done_d      = good_hit;
        err_d       = short_hit | long_hit;
        err_short_d = err_short_q | short_hit;
        err_long_d  = err_long_q | long_hit;
        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(good_hit);
        err_cnt_d   = (err_d & ~&err_cnt_q) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
    end
    assign fifo_wr_en = out_valid_q;
    assign fifo_din   = out_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_axis_fifo_s_frame_sink.sv
// tb_axis_fifo_s_frame_sink: directed bench for the frame sink with L=8 and 2-bit counters
module tb_axis_fifo_s_frame_sink;
    localparam int W = 32;
    localparam int L = 8;
    logic         clk = 1'b0, rst_n = 1'b0, tvalid = 1'b0, tlast = 1'b0, full = 1'b0;
    logic [W-1:0] tdata = '0;
    logic [3:0]   tkeep = 4'hf;
    logic         tready, wr_en, done, err, e_short, e_long;
    logic [W-1:0] din;
    logic [1:0]   f_cnt, e_cnt;
    int           vectors = 0, miscompares = 0, cyc = 0;
    int           n_done, n_err, err_cyc, first_wr, last_wr, ready_low, stall_cnt, acc_cyc, acc7;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_din;
    logic [W-1:0] cap[$];

    axis_fifo_s_frame_sink #(.C_S_AXIS_TDATA_WIDTH(W), .LENGTH_OF_FRAME(L), .CNT_WIDTH(2)) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tready(tready), .fifo_din(din),
        .fifo_wr_en(wr_en), .fifo_full(full), .frame_done(done), .frame_err(err),
        .err_short(e_short), .err_long(e_long), .frame_cnt(f_cnt), .err_cnt(e_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (wr_en && !full) begin
                cap.push_back(din);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (wr_en && full) begin
                chk("stall_tready", tready, 0);
                if (prev_stall) chk("stall_din_hold", din, prev_din);
                prev_din = din;
                stall_cnt++;
            end
            prev_stall = wr_en && full;
            if (!full && tready !== 1'b1) ready_low++;
            if (done) n_done++;
            if (err) begin
                n_err++;
                err_cyc = cyc;
            end
        end
    end

    task automatic clear();
        cap.delete();
        n_done = 0; n_err = 0; err_cyc = -1; first_wr = -1; last_wr = -1;
        ready_low = 0; stall_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear();
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        int n = 0;
        logic acc;
        tvalid = 1'b1; tdata = d; tlast = last;
        do begin
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1 n++;
        end while (!acc && n < 100);
        if (!acc) chk("send_timeout", 0, 1);
        acc_cyc = cyc;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_frame(input int base, input int n, input int last_idx);
        for (int i = 0; i < n; i++) send(W'(base + i), i == last_idx);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        chk({tag, "_len"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++) chk(tag, cap[i], W'(base + i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear();
        tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_din", din, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnts", {e_short, e_long, f_cnt, e_cnt}, 0);
        tvalid = 1'b0;
        rst_n = 1'b1;
        clear();

        send_frame(0, 8, 7);
        send_frame(8, 8, 7);
        send_frame(16, 8, 7);
        drain();
        check_stream("b2b_data", 0, 24);
        chk("b2b_consecutive", last_wr - first_wr, 23);
        chk("b2b_done", n_done, 3);
        chk("b2b_frame_cnt", f_cnt, 3);
        chk("b2b_err_cnt", e_cnt, 0);
        chk("b2b_ready_low", ready_low, 0);

        do_reset();
        fork
            begin
                repeat (3) @(posedge clk);
                #1 full = 1'b1;
                repeat (5) @(posedge clk);
                #1 full = 1'b0;
            end
        join_none
        send_frame(100, 8, 7);
        drain();
        check_stream("bp_data", 100, 8);
        chk("bp_stall_cycles", stall_cnt, 5);
        chk("bp_done", n_done, 1);
        chk("bp_frame_cnt", f_cnt, 1);

        do_reset();
        send_frame(200, 5, 4);
        drain();
        chk("short_err", n_err, 1);
        chk("short_flag", {e_short, e_long}, 2'b10);
        chk("short_err_cnt", e_cnt, 1);
        send_frame(300, 8, 7);
        drain();
        chk("short_next_done", n_done, 1);
        chk("short_next_frame_cnt", f_cnt, 1);
        chk("short_len", cap.size(), 13);
        for (int i = 0; i < 5; i++) chk("short_data", cap[i], W'(200 + i));
        for (int i = 0; i < 8; i++) chk("short_next_data", cap[5 + i], W'(300 + i));

        do_reset();
        acc7 = -1;
        for (int i = 0; i < 12; i++) begin
            send(W'(400 + i), i == 11);
            if (i == 7) acc7 = acc_cyc;
        end
        drain();
        check_stream("long_data", 400, 8);
        chk("long_err", n_err, 1);
        chk("long_err_timing", err_cyc, acc7);
        chk("long_flag", {e_short, e_long}, 2'b01);
        chk("long_err_cnt", e_cnt, 1);
        chk("long_ready_low", ready_low, 0);
        send_frame(500, 8, 7);
        drain();
        chk("long_next_done", n_done, 1);
        chk("long_next_frame_cnt", f_cnt, 1);
        chk("long_next_len", cap.size(), 16);

        send(W'(600), 1'b0);
        send(W'(601), 1'b0);
        send(W'(602), 1'b0);
        full = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_din", din, 0);
        chk("arst_tready", tready, 0);
        chk("arst_pulses", {done, err}, 0);
        chk("arst_flags", {e_short, e_long}, 0);
        chk("arst_cnts", {f_cnt, e_cnt}, 0);
        repeat (2) @(posedge clk);
        #1 full = 1'b0;
        rst_n = 1'b1;
        clear();
        send_frame(700, 8, 7);
        drain();
        check_stream("arst_frame", 700, 8);
        chk("arst_frame_cnt", f_cnt, 1);
        chk("arst_err_cnt", e_cnt, 0);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_frame(800 + 2 * k, 2, 1);
            drain();
            if (k == 1) chk("sat_err_cnt_2", e_cnt, 2);
            if (k == 2) chk("sat_err_cnt_3", e_cnt, 3);
        end
        chk("sat_err_cnt_hold", e_cnt, 3);
        chk("sat_err_pulses", n_err, 5);
        chk("sat_short_flag", e_short, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
